pixel_depth_writer: RTL
=======================

# pixel_depth_writer

Consumer end of the rasterizer pixel stream. Accepts one pixel per cycle (x, y, 2-bit depth, 16-bit color, write strobe, done strobe) from the edge rasterizer. Performs a read-modify-write depth test against an on-chip 2-bit z-buffer and issues framebuffer color writes for passing pixels. Also owns a clear sequencer that initializes the z-buffer and framebuffer, both after reset and on request.

## Interface
Parameters:
- `SCREEN_W_LOG2`, default 8: log2 of screen width; the x range is 0..2^SCREEN_W_LOG2-1.
- `SCREEN_H_LOG2`, default 8: log2 of screen height.
- `CLEAR_COLOR`, default 16'h0000: color written to every framebuffer address during a clear.

Ports:
- `clock`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-high.
- `in_sig_rasterize_write_pixel`, in, 1: the current pixel is valid.
- `in_sig_rasterize_done`, in, 1: upstream triangle finished; a level, edge-detected here.
- `in_pixel_x`, `in_pixel_y`, in, 16 each: pixel coordinates.
- `in_pixel_depth`, in, 2: pixel depth; 0 is nearest.
- `in_pixel_color`, in, 16: pixel color.
- `in_sig_clear`, in, 1: request a full clear.
- `out_fb_we`, out, 1: framebuffer write enable.
- `out_fb_addr`, out, SCREEN_W_LOG2+SCREEN_H_LOG2: framebuffer address, {y, x}.
- `out_fb_data`, out, 16: framebuffer color.
- `out_sig_busy`, out, 1: a clear is in progress.
- `out_sig_triangle_done`, out, 1: one-cycle pulse once the triangle's last pixel is committed.
- `out_sig_drop_err`, out, 1: sticky; a pixel arrived while busy.
- `out_pass_count`, `out_fail_count`, out, 16 each: saturating counts of pixels that passed and failed the depth test.

## Operation
- The FSM has two states, CLEAR and RUN. Reset forces CLEAR with the sweep address at 0.
- **CLEAR:**
  - Each cycle, write z=2'b11 and fb color=CLEAR_COLOR to the sweep address, then increment the address.
  - After writing address 2^(W+H)-1, go to RUN.
  - `out_sig_busy` is 1 throughout CLEAR.
- **Clear request in RUN:** `in_sig_clear`=1 drains the pipeline (at most 2 cycles with no new pixels accepted), then enters CLEAR at address 0.
- **Clear request in CLEAR:** ignored; the sweep is not restarted.
- **Pixels while busy:** a strobe during CLEAR or the drain is discarded and sets `out_sig_drop_err`. The flag is cleared only by reset.
- **Clipping:** a pixel whose x bits above SCREEN_W_LOG2, or y bits above SCREEN_H_LOG2, are nonzero is discarded silently. It is not counted and is not an error.
- **Depth test:** pass when in_depth <= stored depth (LEQUAL).
  - Pass: write the new depth to the z-buffer, write the color to the framebuffer, and increment `out_pass_count`.
  - Fail: no writes; increment `out_fail_count`.
  - Both counters saturate at 16'hFFFF and are cleared by reset only.
- **Forwarding:** the z-buffer RAM returns old data on a same-cycle read/write to the same address. If the pixel now in stage 2 reads the same address that the previous pixel committed on the same edge, stage 2 uses the committed depth instead of the RAM output. There is at most one conflicting older pixel, so one-deep forwarding is sufficient.
- **Triangle done:** a rising edge of `in_sig_rasterize_done` is delayed through the same 2 stages as pixel data, so it pulses after the last pixel's fb write.

## Timing
- **Stage 1 (edge k):** register the strobe, address, depth and color; issue the z read.
- **Stage 2 (edge k+1):** capture the z data (forwarded if needed) and compare combinationally.
- **Commit (edge k+2):** the registered `out_fb_we`, addr and data, the z write and the counter updates take effect.
- **Latency:** strobe sampled at edge k → `out_fb_we`=1 after edge k+2.
- **Throughput:** 1 pixel per cycle, with no backpressure.
- **Clear duration:** 2^(W+H) cycles of `out_fb_we`=1.
- **Reset values:**
  - `out_fb_we`=0, `out_fb_addr`=0, `out_fb_data`=0.
  - `out_sig_busy`=1 while in reset, because the state is CLEAR.
  - `out_sig_triangle_done`=0, `out_sig_drop_err`=0, both counters =0.
- **Reset mid-operation:** pipeline contents are lost, no write is issued, and the sweep restarts at address 0.

## Structure
- **Shared package `raster_pkg`:**
  - depth width (2) and color width (16).
  - DEPTH_FAR = 2'b11.
  - The FSM state enum {CLEAR, RUN}.
- **Sub-module `depth_buffer_ram`:** 1 read port, 1 write port, synchronous 1-cycle read, read-old-data behaviour, 2^(W+H) x 2 bits, no reset.
- **This block** contains the FSM, pipeline registers, forwarding mux, counters and done delay.

## Test plan
- **Reset release:** deassert reset with W=H=2 → `out_sig_busy` stays 1 for 16 cycles with `out_fb_addr` = 0..15 and data CLEAR_COLOR, then drops to 0.
- **Basic pass/fail:**
  - Pixel (1,2) depth 1 color 16'hABCD → fb write addr 9 two edges later; pass_count=1.
  - Then (1,2) depth 2 → no write; fail_count=1.
  - Then (1,2) depth 1 → write; pass_count=2.
- **Forwarding hazard:** back-to-back pixels on consecutive cycles at (3,3), depth 2 then depth 2 → both write (the second sees the forwarded depth 2).
  - The sequence depth 1 then depth 2 → the second is rejected.
- **Clipping:** x=16'h0004 with W=2 → no write, counters unchanged, drop_err=0.
- **Clear while pixels stream:**
  - `in_sig_clear` with 2 pixels in flight → both commit, then the sweep starts.
  - A strobe during the sweep → no write and `out_sig_drop_err`=1.
- **Done and saturation:**
  - `in_sig_rasterize_done` rising on the same cycle as the last pixel → `out_sig_triangle_done` pulses on the same cycle as that pixel's `out_fb_we`.
  - 65536 passing pixels → pass_count holds 16'hFFFF.

Source files
------------

// File: rtl/raster_pkg.sv
// raster_pkg: shared widths, far-depth constant and writer FSM states
package raster_pkg;
    localparam int DEPTH_W = 2;
    localparam int COLOR_W = 16;
    localparam logic [DEPTH_W-1:0] DEPTH_FAR = 2'b11;
    typedef enum logic {CLEAR, RUN} state_t;
endpackage

// File: rtl/depth_buffer_ram.sv
// depth_buffer_ram: 1R1W z-buffer, synchronous read returning old data on a same-address write
module depth_buffer_ram
    import raster_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic               clock,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [DEPTH_W-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [DEPTH_W-1:0] rdata
);
    logic [DEPTH_W-1:0] mem [2**AW];

    // write and registered read share one edge, so a colliding read sees the pre-write value
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/pixel_depth_writer.sv
// pixel_depth_writer: depth-tested framebuffer writer with z-buffer/framebuffer clear sequencer
module pixel_depth_writer
    import raster_pkg::*;
#(
    parameter int              SCREEN_W_LOG2 = 8,
    parameter int              SCREEN_H_LOG2 = 8,
    parameter logic [COLOR_W-1:0] CLEAR_COLOR = 16'h0000
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   in_sig_rasterize_write_pixel,
    input  logic                                   in_sig_rasterize_done,
    input  logic [15:0]                            in_pixel_x,
    input  logic [15:0]                            in_pixel_y,
    input  logic [DEPTH_W-1:0]                     in_pixel_depth,
    input  logic [COLOR_W-1:0]                     in_pixel_color,
    input  logic                                   in_sig_clear,
    output logic                                   out_fb_we,
    output logic [SCREEN_W_LOG2+SCREEN_H_LOG2-1:0] out_fb_addr,
    output logic [COLOR_W-1:0]                     out_fb_data,
    output logic                                   out_sig_busy,
    output logic                                   out_sig_triangle_done,
    output logic                                   out_sig_drop_err,
    output logic [15:0]                            out_pass_count,
    output logic [15:0]                            out_fail_count
);
    localparam int AW = SCREEN_W_LOG2 + SCREEN_H_LOG2;

    state_t             state, state_next;
    logic               drain;
    logic [AW-1:0]      sweep;
    logic               s1_valid, s2_valid;
    logic [AW-1:0]      s1_addr, s2_addr;
    logic [DEPTH_W-1:0] s1_depth, s2_depth;
    logic [COLOR_W-1:0] s1_color, s2_color;
    logic               fwd_hit;
    logic [DEPTH_W-1:0] fwd_depth, ram_q, z_cur;
    logic               clip, accept, depth_ok, commit;
    logic               ram_we;
    logic [AW-1:0]      ram_waddr;
    logic [DEPTH_W-1:0] ram_wdata;
    logic               done_prev, done_d1, done_d2;

    depth_buffer_ram #(.AW(AW)) u_zbuf (
        .clock (clock),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (s1_addr),
        .rdata (ram_q)
    );

    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= CLEAR;
        else       state <= state_next;
    end

    // leave CLEAR after the last address; leave RUN once the drain has emptied stage 1
    always_comb begin
        state_next = (state == CLEAR) ? ((&sweep) ? RUN : CLEAR)
                                      : ((drain && !s1_valid) ? CLEAR : RUN);
    end

    // acceptance, depth compare with forwarding, and the shared z/fb write port
    always_comb begin
        out_sig_busy = (state == CLEAR);
        clip         = (|(in_pixel_x >> SCREEN_W_LOG2)) || (|(in_pixel_y >> SCREEN_H_LOG2));
        accept       = in_sig_rasterize_write_pixel && (state == RUN) && !drain && !clip;
        z_cur        = fwd_hit ? fwd_depth : ram_q;
        depth_ok     = (s2_depth <= z_cur);
        commit       = s2_valid && depth_ok;
        ram_we       = out_sig_busy || commit;
        ram_waddr    = out_sig_busy ? sweep : s2_addr;
        ram_wdata    = out_sig_busy ? DEPTH_FAR : s2_depth;
    end

    // sweep address and drain flag for clear requests made while running
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sweep <= '0;
            drain <= 1'b0;
        end else begin
            sweep <= (state == CLEAR) ? sweep + 1'b1 : '0;
            drain <= (state == RUN) && (drain ? s1_valid : in_sig_clear);
        end
    end

    // two-stage pixel pipeline plus forwarding of the depth committed on the stage-2 read edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_addr   <= '0;
            s1_depth  <= '0;
            s1_color  <= '0;
            s2_valid  <= 1'b0;
            s2_addr   <= '0;
            s2_depth  <= '0;
            s2_color  <= '0;
            fwd_hit   <= 1'b0;
            fwd_depth <= '0;
        end else begin
            s1_valid  <= accept;
            s1_addr   <= {in_pixel_y[SCREEN_H_LOG2-1:0], in_pixel_x[SCREEN_W_LOG2-1:0]};
            s1_depth  <= in_pixel_depth;
            s1_color  <= in_pixel_color;
            s2_valid  <= s1_valid;
            s2_addr   <= s1_addr;
            s2_depth  <= s1_depth;
            s2_color  <= s1_color;
            fwd_hit   <= commit && (s2_addr == s1_addr);
            fwd_depth <= s2_depth;
        end
    end

    // registered framebuffer port mirrors the z-buffer write port
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_fb_we   <= 1'b0;
            out_fb_addr <= '0;
            out_fb_data <= '0;
        end else begin
            out_fb_we   <= ram_we;
            out_fb_addr <= ram_waddr;
            out_fb_data <= out_sig_busy ? CLEAR_COLOR : s2_color;
        end
    end

    // saturating pass/fail counters and sticky drop flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_pass_count   <= '0;
            out_fail_count   <= '0;
            out_sig_drop_err <= 1'b0;
        end else begin
            if (commit && out_pass_count != 16'hFFFF) out_pass_count <= out_pass_count + 1'b1;
            if (s2_valid && !depth_ok && out_fail_count != 16'hFFFF) out_fail_count <= out_fail_count + 1'b1;
            out_sig_drop_err <= out_sig_drop_err || (in_sig_rasterize_write_pixel && (out_sig_busy || drain));
        end
    end

    // triangle-done rising edge delayed to line up with the last pixel's framebuffer write
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done_prev             <= 1'b0;
            done_d1               <= 1'b0;
            done_d2               <= 1'b0;
            out_sig_triangle_done <= 1'b0;
        end else begin
            done_prev             <= in_sig_rasterize_done;
            done_d1               <= in_sig_rasterize_done && !done_prev;
            done_d2               <= done_d1;
            out_sig_triangle_done <= done_d2;
        end
    end
endmodule
